ps2_kbd_event_ctrl: RTL and testbench

//  Sequences the raw PS/2 keyboard byte stream (ps2kbd code/strobe/err) into whole key events.

---
 rtl/ps2_kbd_pkg.sv | 43 ++++
 rtl/ps2_kbd_evt_fifo.sv | 50 +++++
 rtl/ps2_kbd_event_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ps2_kbd_event_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard event controller.
// Contents: FSM state enum, packed event payload, prefix/protocol byte
// constants and small byte-classification helpers.
package ps2_kbd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    REL,
    EXT_REL,
    PAUSE
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } kbd_evt_t;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_REL   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;
  localparam logic [7:0] BAT_OK    = 8'hAA;
  localparam logic [7:0] ACK       = 8'hFA;
  localparam logic [7:0] RESEND    = 8'hFE;
  localparam logic [7:0] ECHO      = 8'hEE;
  localparam logic [7:0] OVR0      = 8'h00;
  localparam logic [7:0] OVR1      = 8'hFF;

  // Pause sequence is E1 followed by seven further bytes.
  localparam int unsigned    SKIP_W     = 3;
  localparam logic [SKIP_W-1:0] PAUSE_SKIP = SKIP_W'(7);

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PFX_EXT) || (b == PFX_REL) || (b == PFX_PAUSE);
  endfunction

  function automatic logic is_protocol(input logic [7:0] b);
    return (b == BAT_OK) || (b == ACK) || (b == RESEND) ||
           (b == ECHO) || (b == OVR0) || (b == OVR1);
  endfunction

endpackage

// File: rtl/ps2_kbd_evt_fifo.sv
// Synchronous FIFO of keyboard events.
// Ports: clk, rst_n (async active-low), push/din write side,
// pop/dout read side (dout is the current head), full, empty.
// A push while full is accepted only when a pop happens in the same cycle.
module ps2_kbd_evt_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  kbd_evt_t din,
  input  logic     pop,
  output kbd_evt_t dout,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  kbd_evt_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            wr_en_c;
  logic            rd_en_c;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en_c = push && (!full || pop);
  assign rd_en_c = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (wr_en_c) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (rd_en_c) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/ps2_kbd_event_ctrl.sv
// PS/2 keyboard event controller: turns the raw ps2kbd byte stream into
// whole key events {code, ext, rel}, queued for the SoC.
// Ports:
//   clk, reset_ni                  clock, async active-low reset
//   ps2_code_i/strobe_i/err_i      byte stream and error pulse from ps2kbd
//   evt_valid_o/ready_i            head-of-queue handshake
//   evt_code_o/ext_o/rel_o         head event fields
//   clear_i                        clears overflow_o and err_cnt_o
//   overflow_o                     sticky: event dropped on full queue
//   err_cnt_o                      saturating error/abort count
// Optional build macro PS2_TYPEMATIC_FILTER_EN: suppresses repeated makes
// of a key already held down (tracked per {ext, code}).
module ps2_kbd_event_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_ni,
  input  logic [7:0]           ps2_code_i,
  input  logic                 ps2_strobe_i,
  input  logic                 ps2_err_i,
  output logic                 evt_valid_o,
  input  logic                 evt_ready_i,
  output logic [7:0]           evt_code_o,
  output logic                 evt_ext_o,
  output logic                 evt_rel_o,
  input  logic                 clear_i,
  output logic                 overflow_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  state_t            state, state_nxt;
  logic [SKIP_W-1:0] skip, skip_nxt;
  logic              cand_push_c;
  logic              cand_filt_c;
  kbd_evt_t          cand_evt_c;
  logic              err_inc_c;
  logic              suppress_c;
  logic              push_c;
  logic              pop_c;
  logic              fifo_full;
  logic              fifo_empty;
  kbd_evt_t          head;

  // State and Pause skip counter.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= IDLE;
      skip  <= '0;
    end else begin
      state <= state_nxt;
      skip  <= skip_nxt;
    end
  end

  // Sequence decode; an error pulse overrides any same-cycle byte.
  always_comb begin
    state_nxt   = state;
    skip_nxt    = skip;
    cand_push_c = 1'b0;
    cand_filt_c = 1'b0;
    cand_evt_c  = '0;
    err_inc_c   = 1'b0;
    if (ps2_err_i) begin
      state_nxt = IDLE;
      skip_nxt  = '0;
      err_inc_c = 1'b1;
    end else if (ps2_strobe_i) begin
      case (state)
        IDLE: begin
          if (ps2_code_i == PFX_EXT) begin
            state_nxt = EXT;
          end else if (ps2_code_i == PFX_REL) begin
            state_nxt = REL;
          end else if (ps2_code_i == PFX_PAUSE) begin
            state_nxt = PAUSE;
            skip_nxt  = PAUSE_SKIP;
          end else if (!is_protocol(ps2_code_i)) begin
            cand_push_c = 1'b1;
            cand_filt_c = 1'b1;
            cand_evt_c  = '{code: ps2_code_i, ext: 1'b0, rel: 1'b0};
          end
        end
        EXT: begin
          if (ps2_code_i == PFX_REL) begin
            state_nxt = EXT_REL;
          end else if (is_prefix(ps2_code_i)) begin
            state_nxt = IDLE;
            err_inc_c = 1'b1;
          end else begin
            state_nxt   = IDLE;
            cand_push_c = 1'b1;
            cand_filt_c = 1'b1;
            cand_evt_c  = '{code: ps2_code_i, ext: 1'b1, rel: 1'b0};
          end
        end
        REL, EXT_REL: begin
          state_nxt = IDLE;
          if (is_prefix(ps2_code_i)) begin
            err_inc_c = 1'b1;
          end else begin
            cand_push_c = 1'b1;
            cand_filt_c = 1'b1;
            cand_evt_c  = '{code: ps2_code_i, ext: (state == EXT_REL), rel: 1'b1};
          end
        end
        PAUSE: begin
          if (skip == SKIP_W'(1)) begin
            state_nxt   = IDLE;
            skip_nxt    = '0;
            cand_push_c = 1'b1;
            cand_evt_c  = '{code: PFX_PAUSE, ext: 1'b0, rel: 1'b0};
          end else begin
            skip_nxt = skip - SKIP_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          skip_nxt  = '0;
        end
      endcase
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  // Held-key bitmap indexed by {ext, code}; make sets, break clears.
  logic [511:0] held;
  logic [8:0]   held_idx_c;

  assign held_idx_c = {cand_evt_c.ext, cand_evt_c.code};
  assign suppress_c = cand_filt_c && !cand_evt_c.rel && held[held_idx_c];

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      held <= '0;
    end else if (cand_push_c && cand_filt_c) begin
      held[held_idx_c] <= !cand_evt_c.rel;
    end
  end
`else
  assign suppress_c = 1'b0;
`endif

  assign push_c = cand_push_c && !suppress_c;
  assign pop_c  = evt_valid_o && evt_ready_i;

  ps2_kbd_evt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_ni),
    .push  (push_c),
    .din   (cand_evt_c),
    .pop   (pop_c),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid_o = !fifo_empty;
  assign evt_code_o  = head.code;
  assign evt_ext_o   = head.ext;
  assign evt_rel_o   = head.rel;

  // Sticky overflow and saturating error count; new events beat clear.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      overflow_o <= 1'b0;
      err_cnt_o  <= '0;
    end else begin
      if (push_c && fifo_full && !pop_c) overflow_o <= 1'b1;
      else if (clear_i)                  overflow_o <= 1'b0;

      if (clear_i)                          err_cnt_o <= err_inc_c ? ERR_CNT_W'(1) : '0;
      else if (err_inc_c && !(&err_cnt_o))  err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ps2_kbd_event_ctrl.sv
// Directed self-checking bench for ps2_kbd_event_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ps2_kbd_event_ctrl;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned ERR_CNT_W = 8;

  logic                 clk = 1'b0;
  logic                 reset_ni;
  logic [7:0]           ps2_code;
  logic                 ps2_strobe;
  logic                 ps2_err;
  logic                 evt_valid;
  logic                 evt_ready;
  logic [7:0]           evt_code;
  logic                 evt_ext;
  logic                 evt_rel;
  logic                 clear;
  logic                 overflow;
  logic [ERR_CNT_W-1:0] err_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ps2_kbd_event_ctrl #(
    .DEPTH     (DEPTH),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .clk          (clk),
    .reset_ni     (reset_ni),
    .ps2_code_i   (ps2_code),
    .ps2_strobe_i (ps2_strobe),
    .ps2_err_i    (ps2_err),
    .evt_valid_o  (evt_valid),
    .evt_ready_i  (evt_ready),
    .evt_code_o   (evt_code),
    .evt_ext_o    (evt_ext),
    .evt_rel_o    (evt_rel),
    .clear_i      (clear),
    .overflow_o   (overflow),
    .err_cnt_o    (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    ps2_code   = c;
    ps2_strobe = 1'b1;
    @(negedge clk);
    ps2_strobe = 1'b0;
  endtask

  task automatic err_pulse();
    @(negedge clk);
    ps2_err = 1'b1;
    @(negedge clk);
    ps2_err = 1'b0;
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Check head against expected event, then pop it.
  task automatic pop_exp(input string tag, input logic [7:0] c, input logic e, input logic r);
    check({tag, "_valid"}, 32'(evt_valid), 32'd1);
    check(tag, 32'({evt_code, evt_ext, evt_rel}), 32'({c, e, r}));
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic expect_empty(input string tag);
    check(tag, 32'(evt_valid), 32'd0);
  endtask

  initial begin
    reset_ni   = 1'b0;
    ps2_code   = '0;
    ps2_strobe = 1'b0;
    ps2_err    = 1'b0;
    evt_ready  = 1'b0;
    clear      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_evt", 32'({evt_code, evt_ext, evt_rel}), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    reset_ni = 1'b1;

    // Single make with ready held high: valid one cycle after strobe, then popped.
    @(negedge clk);
    ps2_code   = 8'h1C;
    ps2_strobe = 1'b1;
    evt_ready  = 1'b1;
    check("t1_pre", 32'(evt_valid), 32'd0);
    @(negedge clk);
    ps2_strobe = 1'b0;
    check("t1_valid", 32'(evt_valid), 32'd1);
    check("t1_evt", 32'({evt_code, evt_ext, evt_rel}), 32'({8'h1C, 1'b0, 1'b0}));
    @(negedge clk);
    evt_ready = 1'b0;
    check("t1_popped", 32'(evt_valid), 32'd0);

    // Extended break, extended make, plain break, protocol bytes.
    send(8'hE0);
    expect_empty("t2_e0");
    send(8'hF0);
    expect_empty("t2_f0");
    send(8'h75);
    pop_exp("t2_ext_rel", 8'h75, 1'b1, 1'b1);
    expect_empty("t2_empty");
    send(8'hE0);
    send(8'h6B);
    pop_exp("t2_ext", 8'h6B, 1'b1, 1'b0);
    send(8'hF0);
    send(8'h1C);
    pop_exp("t2_rel", 8'h1C, 1'b0, 1'b1);
    send(8'hAA);
    send(8'hFA);
    send(8'h00);
    expect_empty("t2_proto");

    // Pause sequence collapses to one event; decoding resumes afterwards.
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    expect_empty("t3_mid");
    send(8'h77);
    pop_exp("t3_pause", 8'hE1, 1'b0, 1'b0);
    expect_empty("t3_once");
    send(8'h1C);
    pop_exp("t3_next", 8'h1C, 1'b0, 1'b0);
    check("t3_err", 32'(err_cnt), 32'd0);

    // Overflow: DEPTH+1 makes with ready low.
    for (int i = 0; i <= int'(DEPTH); i++) send(8'h10 + 8'(i));
    check("t4_ovf", 32'(overflow), 32'd1);
    clear_pulse();
    check("t4_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < int'(DEPTH); i++) pop_exp($sformatf("t4_pop%0d", i), 8'h10 + 8'(i), 1'b0, 1'b0);
    expect_empty("t4_empty");
    check("t4_ovf_stay", 32'(overflow), 32'd0);

    // Error mid-sequence, abort on bad prefix, clear priority, saturation.
    send(8'hE0);
    err_pulse();
    check("t5_err1", 32'(err_cnt), 32'd1);
    expect_empty("t5_noevt");
    send(8'h74);
    pop_exp("t5_after_err", 8'h74, 1'b0, 1'b0);
    send(8'hF0);
    send(8'hE0);
    check("t5_abort", 32'(err_cnt), 32'd2);
    expect_empty("t5_abort_noevt");
    send(8'h33);
    pop_exp("t5_after_abort", 8'h33, 1'b0, 1'b0);
    @(negedge clk);
    clear   = 1'b1;
    ps2_err = 1'b1;
    @(negedge clk);
    clear   = 1'b0;
    ps2_err = 1'b0;
    check("t5_clr_vs_err", 32'(err_cnt), 32'd1);
    clear_pulse();
    check("t5_clr", 32'(err_cnt), 32'd0);
    repeat (260) err_pulse();
    check("t5_sat", 32'(err_cnt), 32'hFF);
    clear_pulse();
    check("t5_sat_clr", 32'(err_cnt), 32'd0);

    // Asynchronous reset in the middle of a break sequence.
    send(8'h22);
    err_pulse();
    send(8'hF0);
    @(negedge clk);
    reset_ni = 1'b0;
    #1;
    check("t5_rst_valid", 32'(evt_valid), 32'd0);
    check("t5_rst_evt", 32'({evt_code, evt_ext, evt_rel}), 32'd0);
    check("t5_rst_err", 32'(err_cnt), 32'd0);
    check("t5_rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset_ni = 1'b1;
    send(8'h1C);
    pop_exp("t5_post_rst", 8'h1C, 1'b0, 1'b0);
    expect_empty("t5_post_empty");

    // Typematic repeats.
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    pop_exp("t6_make0", 8'h1C, 1'b0, 1'b0);
`ifndef PS2_TYPEMATIC_FILTER_EN
    pop_exp("t6_make1", 8'h1C, 1'b0, 1'b0);
    pop_exp("t6_make2", 8'h1C, 1'b0, 1'b0);
`endif
    pop_exp("t6_break", 8'h1C, 1'b0, 1'b1);
    expect_empty("t6_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
